// File: rtl/accumulator_mc_sat.sv
// accumulator_mc_sat: time-multiplexed multi-channel signed accumulator.
// Stage 1 registers the incoming sample. Stage 2 does a single-cycle
// read-modify-write on the addressed channel, with optional saturation and
// sticky per-channel overflow flags. The read port is write-first, so a read
// returns the value the accumulator holds after the same edge's update.
module accumulator_mc_sat #(
  parameter int DATA_W   = 20,
  parameter int ACC_W    = 38,
  parameter int CHANNELS = 4,
  parameter int SATURATE = 1,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [CH_W-1:0]          in_ch,
  input  logic                     subtract_i,
  input  logic                     load_i,
  input  logic signed [DATA_W-1:0] A,
  input  logic                     clear_all,
  output logic                     out_valid,
  output logic [CH_W-1:0]          out_ch,
  output logic signed [ACC_W-1:0]  P,
  output logic [CHANNELS-1:0]      ovf,
  input  logic                     rd_en,
  input  logic [CH_W-1:0]          rd_ch,
  output logic signed [ACC_W-1:0]  rd_data
);

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // Stage-1 registers
  logic              s1_valid_q;
  logic [CH_W-1:0]   s1_ch_q;
  logic              s1_sub_q;
  logic              s1_load_q;
  logic [DATA_W-1:0] s1_a_q;

  // Accumulator state and its next value
  logic [ACC_W-1:0]    acc_q [CHANNELS];
  logic [ACC_W-1:0]    acc_d [CHANNELS];
  logic [CHANNELS-1:0] ovf_q;
  logic [CHANNELS-1:0] ovf_d;

  // Stage-2 output and read-port registers
  logic             out_valid_q;
  logic [CH_W-1:0]  out_ch_q;
  logic [ACC_W-1:0] p_q;
  logic [ACC_W-1:0] rd_data_q;
  logic [ACC_W-1:0] rd_data_d;

  // Stage-2 datapath
  logic             s1_hit;
  logic             wr_en;
  logic [ACC_W-1:0] acc_sel;
  logic [ACC_W-1:0] rd_sel;
  logic [ACC_W:0]   a_ext;
  logic [ACC_W:0]   acc_ext;
  logic [ACC_W:0]   sum_w;
  logic             ovf_hit;
  logic [ACC_W-1:0] new_val;

  // Out-of-range channels are silently dropped; a clear discards the update.
  assign s1_hit = s1_valid_q && (int'(s1_ch_q) < CHANNELS);
  assign wr_en  = s1_hit && !clear_all;

  // Select the accumulator addressed by stage 1 and by the read port.
  always_comb begin
    acc_sel = '0;
    rd_sel  = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (int'(s1_ch_q) == c) acc_sel = acc_q[c];
      if (int'(rd_ch) == c)   rd_sel  = acc_q[c];
    end
  end

  // One extra guard bit: overflow shows up as the top two bits disagreeing.
  assign a_ext   = {{(ACC_W + 1 - DATA_W){s1_a_q[DATA_W-1]}}, s1_a_q};
  assign acc_ext = {acc_sel[ACC_W-1], acc_sel};
  assign sum_w   = s1_sub_q ? (acc_ext - a_ext) : (acc_ext + a_ext);
  assign ovf_hit = !s1_load_q && (sum_w[ACC_W] != sum_w[ACC_W-1]);

  // Choose load value, clamped value or wrapped sum for write-back.
  always_comb begin
    new_val = sum_w[ACC_W-1:0];
    if (s1_load_q) begin
      new_val = a_ext[ACC_W-1:0];
    end else if (ovf_hit && (SATURATE != 0)) begin
      // The guard bit carries the sign of the true result.
      new_val = sum_w[ACC_W] ? ACC_MIN : ACC_MAX;
    end
  end

  // Next-state for every channel: clear wins, else the addressed channel updates.
  always_comb begin
    ovf_d = ovf_q;
    for (int c = 0; c < CHANNELS; c++) begin
      acc_d[c] = acc_q[c];
      if (clear_all) begin
        acc_d[c] = '0;
        ovf_d[c] = 1'b0;
      end else if (wr_en && (int'(s1_ch_q) == c)) begin
        acc_d[c] = new_val;
        if (ovf_hit) ovf_d[c] = 1'b1;
      end
    end
  end

  // Write-first read: forward the same-edge update, zero on clear or bad channel.
  always_comb begin
    rd_data_d = '0;
    if (clear_all) begin
      rd_data_d = '0;
    end else if (wr_en && (rd_ch == s1_ch_q)) begin
      rd_data_d = new_val;
    end else if (int'(rd_ch) < CHANNELS) begin
      rd_data_d = rd_sel;
    end
  end

  // Stage-1 capture of the incoming sample, every cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_ch_q    <= '0;
      s1_sub_q   <= 1'b0;
      s1_load_q  <= 1'b0;
      s1_a_q     <= '0;
    end else begin
      s1_valid_q <= in_valid;
      s1_ch_q    <= in_ch;
      s1_sub_q   <= subtract_i;
      s1_load_q  <= load_i;
      s1_a_q     <= A;
    end
  end

  // Accumulator bank and sticky overflow flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < CHANNELS; c++) acc_q[c] <= '0;
      ovf_q <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) acc_q[c] <= acc_d[c];
      ovf_q <= ovf_d;
    end
  end

  // Stage-2 result register: P/out_ch hold when no update is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      p_q         <= '0;
    end else begin
      out_valid_q <= wr_en;
      if (wr_en) begin
        out_ch_q <= s1_ch_q;
        p_q      <= new_val;
      end
    end
  end

  // Register-read port, updated only on request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_q <= '0;
    end else if (rd_en) begin
      rd_data_q <= rd_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign P         = p_q;
  assign ovf       = ovf_q;
  assign rd_data   = rd_data_q;

endmodule
